cpu0_uart_out: RTL and testbench

- Memory-mapped console output port, downstream of the cpu0 core on its memory bus.
- Snoops core write cycles addressed to IOADDR (0x80000) and unpacks the written data into bytes.
- Buffers the bytes in a FIFO and drains them as 8N1 serial frames on tx.
- Replaces the simulation-only character print with synthesizable output. The core and memory0 are unchanged.

---
 rtl/cpu0_pkg.sv | 17 +
 rtl/cpu0_byte_fifo.sv | 40 ++++
 rtl/cpu0_uart_out.sv | 114 +++++++++++
 tb/tb_cpu0_uart_out.sv | 274 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu0_pkg.sv
// cpu0_pkg: size codes, console address, state enums and byte filter shared by cpu0 console output
package cpu0_pkg;
  localparam logic [1:0] BYTE  = 2'b00;
  localparam logic [1:0] INT16 = 2'b01;
  localparam logic [1:0] INT24 = 2'b10;
  localparam logic [1:0] INT32 = 2'b11;
  localparam logic [31:0] IOADDR_DEF = 32'h0008_0000;
  typedef enum logic {U_IDLE, U_PUSH} ustate_t;
  typedef enum logic [1:0] {T_IDLE, T_START, T_DATA, T_STOP} tstate_t;
  // Bit k set means byte k of the store is sent; a zero byte0 silences every multi-byte store
  function automatic logic [3:0] emit_mask(input logic [1:0] size, input logic [31:0] data);
    logic [3:0] m;
    m = 4'b0001;
    for (int k = 1; k < 4; k++) m[k] = (int'(size) >= k) && (data[8*k +: 8] != 8'h00);
    return (size != BYTE && data[7:0] == 8'h00) ? 4'b0000 : m;
  endfunction
endpackage

// File: rtl/cpu0_byte_fifo.sv
// cpu0_byte_fifo: synchronous first-word-fall-through byte FIFO
// ports: clock, reset (sync, active-high); push/din write; pop/dout read (dout valid while !empty);
//        full, empty, count status. A push while full is dropped unless a pop happens in the same clock.
module cpu0_byte_fifo #(
  parameter int DEPTH = 16
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     push,
  input  logic [7:0]               din,
  input  logic                     pop,
  output logic [7:0]               dout,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);
  localparam int AW = $clog2(DEPTH);
  logic [7:0] mem [DEPTH];
  logic [AW-1:0] wr, rd;
  logic do_push, do_pop;
  assign do_pop = pop & ~empty;
  assign do_push = push & (~full | do_pop);
  assign full = count == (AW+1)'(DEPTH);
  assign empty = count == '0;
  assign dout = mem[rd];
  always_ff @(posedge clock) begin
    if (reset) begin
      wr <= '0;
      rd <= '0;
      count <= '0;
    end else begin
      if (do_push) begin
        mem[wr] <= din;
        wr <= wr + 1'b1;
      end
      if (do_pop) rd <= rd + 1'b1;
      count <= count + (AW+1)'(do_push) - (AW+1)'(do_pop);
    end
  end
endmodule

// File: rtl/cpu0_uart_out.sv
// cpu0_uart_out: snoops cpu0 stores to the console port and sends the bytes as 8N1 serial frames
// ports: clock, reset (sync, active-high); m_en/m_rw/m_size/mar/mdr core bus (snooped only);
//        tx serial line, tx_busy frame in progress, fifo_count bytes queued,
//        overflow sticky lost-data flag, clr_ovf clears it (a new loss in the same clock wins).
module cpu0_uart_out
  import cpu0_pkg::*;
#(
  parameter logic [31:0] IOADDR = IOADDR_DEF,
  parameter int FIFO_DEPTH = 16,
  parameter int CLKS_PER_BIT = 434
) (
  input  logic                          clock,
  input  logic                          reset,
  input  logic                          m_en,
  input  logic                          m_rw,
  input  logic [1:0]                    m_size,
  input  logic [31:0]                   mar,
  input  logic [31:0]                   mdr,
  output logic                          tx,
  output logic                          tx_busy,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
  output logic                          overflow,
  input  logic                          clr_ovf
);
  localparam int CW = $clog2(CLKS_PER_BIT);
  logic hit, hit_q, accept;
  ustate_t ust;
  logic [31:0] hold;
  logic [3:0] mask;
  logic push, pop, full, empty;
  logic [7:0] dout;
  tstate_t tst;
  logic [CW-1:0] cnt;
  logic [2:0] bit_idx;
  logic [7:0] sh;
  logic last;
  // The core holds m_en across several clocks per store; only the rising edge of hit counts
  assign hit = m_en & ~m_rw & (mar == IOADDR);
  assign accept = hit & ~hit_q;
  // hold and mask shift together so the current candidate byte is always hold[7:0]
  assign push = (ust == U_PUSH) & mask[0];
  assign pop = (tst == T_IDLE) & ~empty;
  assign last = cnt == CW'(CLKS_PER_BIT - 1);
  assign tx_busy = tst != T_IDLE;
  cpu0_byte_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clock (clock),
    .reset (reset),
    .push  (push),
    .din   (hold[7:0]),
    .pop   (pop),
    .dout  (dout),
    .full  (full),
    .empty (empty),
    .count (fifo_count)
  );
  always_ff @(posedge clock) begin
    if (reset) begin
      hit_q <= 1'b0;
      ust <= U_IDLE;
      hold <= '0;
      mask <= '0;
      overflow <= 1'b0;
    end else begin
      hit_q <= hit;
      overflow <= (accept & (ust != U_IDLE)) | (push & full & ~pop) | (overflow & ~clr_ovf);
      if (ust == U_IDLE) begin
        if (accept) begin
          hold <= mdr;
          mask <= emit_mask(m_size, mdr);
          ust <= U_PUSH;
        end
      end else begin
        hold <= hold >> 8;
        mask <= mask >> 1;
        if (mask[3:1] == 3'b000) ust <= U_IDLE;
      end
    end
  end
  always_ff @(posedge clock) begin
    if (reset) begin
      tst <= T_IDLE;
      cnt <= '0;
      bit_idx <= '0;
      sh <= '0;
      tx <= 1'b1;
    end else begin
      cnt <= (tst == T_IDLE || last) ? '0 : cnt + 1'b1;
      case (tst)
        T_IDLE: if (!empty) begin
          sh <= dout;
          tst <= T_START;
          tx <= 1'b0;
        end
        T_START: if (last) begin
          tst <= T_DATA;
          bit_idx <= '0;
          tx <= sh[0];
        end
        T_DATA: if (last) begin
          if (bit_idx == 3'd7) begin
            tst <= T_STOP;
            tx <= 1'b1;
          end else begin
            bit_idx <= bit_idx + 1'b1;
            sh <= sh >> 1;
            tx <= sh[1];
          end
        end
        T_STOP: if (last) tst <= T_IDLE;
        default: tst <= T_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_cpu0_uart_out.sv
// tb_cpu0_uart_out: scoreboard bench decoding tx frames against bytes expected from each store
module tb_cpu0_uart_out;
  import cpu0_pkg::*;
  localparam int CPB = 4;
  localparam int DEPTH = 4;
  localparam logic [31:0] IO = 32'h0008_0000;
  logic clock = 1'b0, reset = 1'b1, m_en = 1'b0, m_rw = 1'b1, clr_ovf = 1'b0;
  logic [1:0] m_size = 2'b00;
  logic [31:0] mar = '0, mdr = '0;
  logic tx, tx_busy, overflow;
  logic [2:0] fifo_count;
  int checks = 0, errors = 0, cyc = 0;
  logic [7:0] exp_q[$];
  int starts[$];
  logic mon_en = 1'b1, in_frame = 1'b0;
  logic [7:0] mon_b, mon_e;

  cpu0_uart_out #(.IOADDR(IO), .FIFO_DEPTH(DEPTH), .CLKS_PER_BIT(CPB)) dut (
    .clock(clock), .reset(reset), .m_en(m_en), .m_rw(m_rw), .m_size(m_size),
    .mar(mar), .mdr(mdr), .tx(tx), .tx_busy(tx_busy), .fifo_count(fifo_count),
    .overflow(overflow), .clr_ovf(clr_ovf)
  );

  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  initial begin
    #2000000;
    $display("FAIL watchdog cycles=%0d required completion", cyc);
    $fatal(1, "watchdog");
  end

  // Frame decoder: first low sample is start clock 0; sample each bit mid-way
  initial forever begin
    @(negedge clock);
    if (mon_en && !reset && tx === 1'b0) begin
      in_frame = 1'b1;
      starts.push_back(cyc);
      repeat (CPB + CPB / 2) @(negedge clock);
      for (int i = 0; i < 8; i++) begin
        mon_b[i] = tx;
        if (i < 7) repeat (CPB) @(negedge clock);
      end
      repeat (CPB) @(negedge clock);
      checks++;
      if (tx !== 1'b1) begin
        errors++;
        $display("FAIL stop_bit got %b required 1", tx);
      end
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_frame got %02h required none", mon_b);
      end else begin
        mon_e = exp_q.pop_front();
        if (mon_b !== mon_e) begin
          errors++;
          $display("FAIL frame_data got %02h required %02h", mon_b, mon_e);
        end
      end
      in_frame = 1'b0;
    end
  end

  task automatic bus_cycle(input logic [31:0] a, input logic [31:0] d, input logic [1:0] s,
                           input logic rw, input int hold);
    @(negedge clock);
    m_en = 1'b1; m_rw = rw; mar = a; mdr = d; m_size = s;
    repeat (hold) @(negedge clock);
    m_en = 1'b0; m_rw = 1'b1;
  endtask

  task automatic wait_idle(input string name);
    int n;
    n = 0;
    while ((exp_q.size() != 0 || tx_busy || fifo_count != 0 || in_frame) && n < 3000) begin
      @(negedge clock);
      n++;
    end
    checks++;
    if (n >= 3000) begin
      errors++;
      $display("FAIL %s_drain queued=%0d required 0", name, exp_q.size());
    end
    repeat (5) @(negedge clock);
  endtask

  task automatic test_reset;
    checks++;
    if ({tx, tx_busy, fifo_count, overflow} !== {1'b1, 1'b0, 3'd0, 1'b0}) begin
      errors++;
      $display("FAIL reset_state got tx=%b busy=%b cnt=%0d ovf=%b required 1 0 0 0",
               tx, tx_busy, fifo_count, overflow);
    end
  endtask

  task automatic test_int32_frames;
    int bad;
    starts.delete();
    exp_q.push_back(8'h48); exp_q.push_back(8'h4F); exp_q.push_back(8'h6B); exp_q.push_back(8'h0A);
    bus_cycle(IO, 32'h0A6B4F48, INT32, 1'b0, 2);
    wait_idle("int32");
    checks++;
    if (starts.size() != 4) begin
      errors++;
      $display("FAIL int32_frame_count got %0d required 4", starts.size());
    end else begin
      bad = 0;
      for (int i = 1; i < 4; i++) if (starts[i] - starts[i-1] != 10 * CPB + 1) bad++;
      if (bad != 0) begin
        errors++;
        $display("FAIL frame_spacing got %0d %0d %0d required 41", starts[1] - starts[0],
                 starts[2] - starts[1], starts[3] - starts[2]);
      end
    end
    checks++;
    if (overflow !== 1'b0) begin
      errors++;
      $display("FAIL int32_single_accept got ovf=%b required 0", overflow);
    end
  endtask

  task automatic test_filter;
    bus_cycle(IO, 32'h00410000, INT32, 1'b0, 1);
    repeat (3) @(negedge clock);
    checks++;
    if (fifo_count !== 3'd0) begin
      errors++;
      $display("FAIL filter_b0_zero_count got %0d required 0", fifo_count);
    end
    bus_cycle(IO, 32'h00004100, INT32, 1'b0, 1);
    repeat (60) @(negedge clock);
    checks++;
    if (tx_busy !== 1'b0 || fifo_count !== 3'd0) begin
      errors++;
      $display("FAIL filter_b0_gate got busy=%b cnt=%0d required 0 0", tx_busy, fifo_count);
    end
    exp_q.push_back(8'h42); exp_q.push_back(8'h41);
    bus_cycle(IO, 32'h00004142, INT16, 1'b0, 1);
    wait_idle("int16");
    exp_q.push_back(8'h41); exp_q.push_back(8'h42); exp_q.push_back(8'h43);
    bus_cycle(IO, 32'hFF434241, INT24, 1'b0, 3);
    wait_idle("int24");
  endtask

  task automatic test_byte_zero;
    exp_q.push_back(8'h00);
    bus_cycle(IO, 32'h12345600, BYTE, 1'b0, 1);
    wait_idle("byte_zero");
  endtask

  task automatic test_decode;
    bus_cycle(32'h0007FFFC, 32'h44434241, INT32, 1'b0, 1);
    bus_cycle(IO, 32'h44434241, INT32, 1'b1, 2);
    repeat (60) @(negedge clock);
    checks++;
    if (tx_busy !== 1'b0 || fifo_count !== 3'd0 || overflow !== 1'b0) begin
      errors++;
      $display("FAIL decode got busy=%b cnt=%0d ovf=%b required 0 0 0", tx_busy, fifo_count, overflow);
    end
  endtask

  task automatic test_busy_drop;
    exp_q.push_back(8'h41); exp_q.push_back(8'h42); exp_q.push_back(8'h43); exp_q.push_back(8'h44);
    bus_cycle(IO, 32'h44434241, INT32, 1'b0, 1);
    bus_cycle(IO, 32'h48474645, INT32, 1'b0, 1);
    repeat (4) @(negedge clock);
    checks++;
    if (overflow !== 1'b1) begin
      errors++;
      $display("FAIL busy_drop_ovf got %b required 1", overflow);
    end
    clr_ovf = 1'b1;
    @(negedge clock);
    clr_ovf = 1'b0;
    checks++;
    if (overflow !== 1'b0) begin
      errors++;
      $display("FAIL clr_ovf got %b required 0", overflow);
    end
    wait_idle("busy_drop");
  endtask

  task automatic test_fifo_overflow;
    exp_q.push_back(8'h41); exp_q.push_back(8'h42); exp_q.push_back(8'h43); exp_q.push_back(8'h44);
    exp_q.push_back(8'h41);
    bus_cycle(IO, 32'h44434241, INT32, 1'b0, 1);
    repeat (4) @(negedge clock);
    checks++;
    if (fifo_count !== 3'd3 || overflow !== 1'b0) begin
      errors++;
      $display("FAIL first_word_queued got cnt=%0d ovf=%b required 3 0", fifo_count, overflow);
    end
    bus_cycle(IO, 32'h44434241, INT32, 1'b0, 1);
    repeat (6) @(negedge clock);
    checks++;
    if (fifo_count !== 3'd4 || overflow !== 1'b1) begin
      errors++;
      $display("FAIL fifo_full_drop got cnt=%0d ovf=%b required 4 1", fifo_count, overflow);
    end
    clr_ovf = 1'b1;
    @(negedge clock);
    clr_ovf = 1'b0;
    checks++;
    if (overflow !== 1'b0) begin
      errors++;
      $display("FAIL fifo_clr_ovf got %b required 0", overflow);
    end
    wait_idle("fifo_overflow");
  endtask

  task automatic test_reset_mid;
    int n, lows;
    mon_en = 1'b0;
    bus_cycle(IO, 32'h00332255, INT24, 1'b0, 1);
    n = 0;
    while (tx !== 1'b0 && n < 50) begin
      @(negedge clock);
      n++;
    end
    checks++;
    if (n >= 50) begin
      errors++;
      $display("FAIL reset_mid_start got tx=%b required 0", tx);
    end
    repeat (17) @(negedge clock);
    checks++;
    if (tx !== 1'b0 || fifo_count !== 3'd2 || tx_busy !== 1'b1) begin
      errors++;
      $display("FAIL reset_mid_bit3 got tx=%b cnt=%0d busy=%b required 0 2 1", tx, fifo_count, tx_busy);
    end
    reset = 1'b1;
    @(negedge clock);
    checks++;
    if (tx !== 1'b1 || fifo_count !== 3'd0 || tx_busy !== 1'b0 || overflow !== 1'b0) begin
      errors++;
      $display("FAIL reset_mid_abort got tx=%b cnt=%0d busy=%b ovf=%b required 1 0 0 0",
               tx, fifo_count, tx_busy, overflow);
    end
    reset = 1'b0;
    lows = 0;
    repeat (100) begin
      @(negedge clock);
      if (tx !== 1'b1 || tx_busy !== 1'b0) lows++;
    end
    checks++;
    if (lows != 0) begin
      errors++;
      $display("FAIL reset_mid_quiet got %0d active clocks required 0", lows);
    end
    mon_en = 1'b1;
  endtask

  initial begin
    repeat (3) @(negedge clock);
    test_reset();
    reset = 1'b0;
    repeat (2) @(negedge clock);
    test_int32_frames();
    test_filter();
    test_byte_zero();
    test_decode();
    test_busy_drop();
    test_fifo_overflow();
    test_reset_mid();
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL leftover_expected got %0d required 0", exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
